// File: rtl/camac_dataway_master.sv
// camac_dataway_master: dataway-side initiator for the CAMAC crate.
// Runs one full dataway cycle per accepted N.A.F command:
// B, N/A/F setup, S1, gap, S2, recovery, then a one-cycle response strobe.
// Optional feature macro: CAMAC_MASTER_QREP_EN. When it is defined, the
// req_qrep port exists and the command repeats while Q=0, up to QREP_MAX attempts.
module camac_dataway_master #(
`ifdef CAMAC_MASTER_QREP_EN
    parameter int QREP_MAX = 16,
`endif
    parameter int T_SETUP  = 4,
    parameter int T_S1     = 2,
    parameter int T_GAP    = 2,
    parameter int T_S2     = 2,
    parameter int T_REC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_n,
    input  logic [3:0]  req_a,
    input  logic [4:0]  req_f,
    input  logic [23:0] req_wdata,
`ifdef CAMAC_MASTER_QREP_EN
    input  logic        req_qrep,
`endif
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        rsp_q,
    output logic        rsp_x,
    output logic        b,
    output logic [23:0] n_sel,
    output logic [3:0]  a,
    output logic [4:0]  f,
    output logic [23:0] write,
    output logic        s1,
    output logic        s2,
    input  logic [23:0] read,
    input  logic        q,
    input  logic        x
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STB1,
        GAP,
        STB2,
        REC,
        DONE
    } state_t;

    localparam int CW = 8;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [4:0]      cmdN_q, cmdN_d;
    logic [3:0]      cmdA_q, cmdA_d;
    logic [4:0]      cmdF_q, cmdF_d;
    logic [23:0]     cmdWdata_q, cmdWdata_d;

    logic            sampleQ_q, sampleQ_d;
    logic            sampleX_q, sampleX_d;
    logic [23:0]     sampleRead_q, sampleRead_d;

    logic            reqReady_q, reqReady_d;
    logic            rspValid_q, rspValid_d;
    logic [23:0]     rspRdata_q, rspRdata_d;
    logic            rspQ_q, rspQ_d;
    logic            rspX_q, rspX_d;

    logic            bOut_q, bOut_d;
    logic [23:0]     nSel_q, nSel_d;
    logic [3:0]      aOut_q, aOut_d;
    logic [4:0]      fOut_q, fOut_d;
    logic [23:0]     writeOut_q, writeOut_d;
    logic            s1Out_q, s1Out_d;
    logic            s2Out_q, s2Out_d;

    logic            accept;
    logic            capture;
    logic            repeatCycle;
    logic            driving;

`ifdef CAMAC_MASTER_QREP_EN
    localparam int AW = $clog2(QREP_MAX) + 1;
    logic            cmdQrep_q, cmdQrep_d;
    logic [AW-1:0]   attempt_q, attempt_d;
`endif

    // Stations 1..24 exist on the dataway; anything else selects nobody.
    function automatic logic stationValid(input logic [4:0] n);
        stationValid = (n != 5'd0) && (n <= 5'd24);
    endfunction

    function automatic logic [23:0] decodeStation(input logic [4:0] n);
        decodeStation = '0;
        if (stationValid(n)) begin
            decodeStation[n - 5'd1] = 1'b1;
        end
    endfunction

    // Counter reload value is the state's length minus one, so it ends at zero.
    function automatic logic [CW-1:0] durationOf(input state_t s);
        case (s)
            SETUP:   durationOf = CW'(T_SETUP - 1);
            STB1:    durationOf = CW'(T_S1 - 1);
            GAP:     durationOf = CW'(T_GAP - 1);
            STB2:    durationOf = CW'(T_S2 - 1);
            REC:     durationOf = CW'(T_REC - 1);
            default: durationOf = '0;
        endcase
    endfunction

    // Next-state, command latch, sampling and next output values (outputs are flopped from these).
    always_comb begin
        accept  = req_valid && reqReady_q;
        capture = (state_q == STB1) && (cnt_q == '0);

`ifdef CAMAC_MASTER_QREP_EN
        repeatCycle = cmdQrep_q && !sampleQ_q && stationValid(cmdN_q) &&
                      (attempt_q < AW'(QREP_MAX - 1));
`else
        repeatCycle = 1'b0;
`endif

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (cnt_q == '0) state_d = STB1;
            STB1:    if (cnt_q == '0) state_d = GAP;
            GAP:     if (cnt_q == '0) state_d = STB2;
            STB2:    if (cnt_q == '0) state_d = REC;
            REC:     if (cnt_q == '0) state_d = repeatCycle ? SETUP : DONE;
            DONE:    state_d = accept ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = (state_d != state_q) ? durationOf(state_d) : (cnt_q - CW'(1));

        cmdN_d     = accept ? req_n     : cmdN_q;
        cmdA_d     = accept ? req_a     : cmdA_q;
        cmdF_d     = accept ? req_f     : cmdF_q;
        cmdWdata_d = accept ? req_wdata : cmdWdata_q;

`ifdef CAMAC_MASTER_QREP_EN
        cmdQrep_d = accept ? req_qrep : cmdQrep_q;
        attempt_d = attempt_q;
        if (accept) begin
            attempt_d = '0;
        end else if ((state_q == REC) && (cnt_q == '0) && repeatCycle) begin
            attempt_d = attempt_q + AW'(1);
        end
`endif

        sampleQ_d    = capture ? q    : sampleQ_q;
        sampleX_d    = capture ? x    : sampleX_q;
        sampleRead_d = capture ? read : sampleRead_q;

        driving    = (state_d == SETUP) || (state_d == STB1) ||
                     (state_d == GAP)   || (state_d == STB2);
        bOut_d     = driving;
        nSel_d     = driving ? decodeStation(cmdN_d) : '0;
        aOut_d     = driving ? cmdA_d : '0;
        fOut_d     = driving ? cmdF_d : '0;
        writeOut_d = (driving && (cmdF_d[4:3] == 2'b10)) ? cmdWdata_d : '0;
        s1Out_d    = (state_d == STB1);
        s2Out_d    = (state_d == STB2);

        reqReady_d = (state_d == IDLE) || (state_d == DONE);
        rspValid_d = (state_d == DONE);

        rspQ_d     = rspQ_q;
        rspX_d     = rspX_q;
        rspRdata_d = rspRdata_q;
        if ((state_d == DONE) && (state_q != DONE)) begin
            rspQ_d     = stationValid(cmdN_q) && sampleQ_q;
            rspX_d     = stationValid(cmdN_q) && sampleX_q;
            rspRdata_d = (stationValid(cmdN_q) && (cmdF_q[4:3] == 2'b00)) ? sampleRead_q : '0;
        end
    end

    // State, command and output registers; reset drops any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmdN_q       <= '0;
            cmdA_q       <= '0;
            cmdF_q       <= '0;
            cmdWdata_q   <= '0;
            sampleQ_q    <= 1'b0;
            sampleX_q    <= 1'b0;
            sampleRead_q <= '0;
            reqReady_q   <= 1'b0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspQ_q       <= 1'b0;
            rspX_q       <= 1'b0;
            bOut_q       <= 1'b0;
            nSel_q       <= '0;
            aOut_q       <= '0;
            fOut_q       <= '0;
            writeOut_q   <= '0;
            s1Out_q      <= 1'b0;
            s2Out_q      <= 1'b0;
`ifdef CAMAC_MASTER_QREP_EN
            cmdQrep_q    <= 1'b0;
            attempt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmdN_q       <= cmdN_d;
            cmdA_q       <= cmdA_d;
            cmdF_q       <= cmdF_d;
            cmdWdata_q   <= cmdWdata_d;
            sampleQ_q    <= sampleQ_d;
            sampleX_q    <= sampleX_d;
            sampleRead_q <= sampleRead_d;
            reqReady_q   <= reqReady_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
            rspQ_q       <= rspQ_d;
            rspX_q       <= rspX_d;
            bOut_q       <= bOut_d;
            nSel_q       <= nSel_d;
            aOut_q       <= aOut_d;
            fOut_q       <= fOut_d;
            writeOut_q   <= writeOut_d;
            s1Out_q      <= s1Out_d;
            s2Out_q      <= s2Out_d;
`ifdef CAMAC_MASTER_QREP_EN
            cmdQrep_q    <= cmdQrep_d;
            attempt_q    <= attempt_d;
`endif
        end
    end

    assign req_ready = reqReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_q     = rspQ_q;
    assign rsp_x     = rspX_q;
    assign b         = bOut_q;
    assign n_sel     = nSel_q;
    assign a         = aOut_q;
    assign f         = fOut_q;
    assign write     = writeOut_q;
    assign s1        = s1Out_q;
    assign s2        = s2Out_q;

endmodule

// File: tb/tb_camac_dataway_master.sv
// Directed testbench for camac_dataway_master with hand-computed expectations.
module tb_camac_dataway_master;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [4:0]  reqN;
    logic [3:0]  reqA;
    logic [4:0]  reqF;
    logic [23:0] reqWdata;
`ifdef CAMAC_MASTER_QREP_EN
    logic        reqQrep;
`endif
    logic        rspValid;
    logic [23:0] rspRdata;
    logic        rspQ;
    logic        rspX;
    logic        bLine;
    logic [23:0] nSel;
    logic [3:0]  aLine;
    logic [4:0]  fLine;
    logic [23:0] writeLine;
    logic        s1;
    logic        s2;
    logic [23:0] readLine;
    logic        qLine;
    logic        xLine;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [4:0]  b2bN;
    logic [3:0]  b2bA;
    logic [4:0]  b2bF;
    logic [23:0] b2bWdata;

    camac_dataway_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_n     (reqN),
        .req_a     (reqA),
        .req_f     (reqF),
        .req_wdata (reqWdata),
`ifdef CAMAC_MASTER_QREP_EN
        .req_qrep  (reqQrep),
`endif
        .rsp_valid (rspValid),
        .rsp_rdata (rspRdata),
        .rsp_q     (rspQ),
        .rsp_x     (rspX),
        .b         (bLine),
        .n_sel     (nSel),
        .a         (aLine),
        .f         (fLine),
        .write     (writeLine),
        .s1        (s1),
        .s2        (s2),
        .read      (readLine),
        .q         (qLine),
        .x         (xLine)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ctlVec();
        return {reqReady, bLine, s1, s2, rspValid};
    endfunction

    // Issues one command, walks cycles 1..13 after accept, ends in the response cycle.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] n, input logic [3:0] ai, input logic [4:0] fi,
                                 input logic [23:0] wd, input logic qi, input logic xi,
                                 input logic [23:0] rd, input logic [23:0] expSel,
                                 input logic [23:0] expWrite, input logic [23:0] expRdata,
                                 input logic expQ, input logic expX, input bit keepValid);
        logic [4:0] expCtl;
        checkOutput({tag, "_ready"}, 32'(reqReady), 32'd1);
        reqN     = n;
        reqA     = ai;
        reqF     = fi;
        reqWdata = wd;
        qLine    = qi;
        xLine    = xi;
        readLine = rd;
        reqValid = 1'b1;
        waitCycle();
        if (keepValid) begin
            reqN     = b2bN;
            reqA     = b2bA;
            reqF     = b2bF;
            reqWdata = b2bWdata;
        end else begin
            reqValid = 1'b0;
        end
        for (int c = 1; c <= 13; c++) begin
            expCtl = {(c == 13), (c <= 10), (c == 5 || c == 6), (c == 9 || c == 10), (c == 13)};
            checkOutput($sformatf("%s_ctl_c%0d", tag, c), 32'(ctlVec()), 32'(expCtl));
            if (c == 1 || c == 5 || c == 11) begin
                checkOutput($sformatf("%s_nsel_c%0d", tag, c), 32'(nSel), (c <= 10) ? 32'(expSel) : 32'd0);
                checkOutput($sformatf("%s_write_c%0d", tag, c), 32'(writeLine), (c <= 10) ? 32'(expWrite) : 32'd0);
                checkOutput($sformatf("%s_af_c%0d", tag, c), 32'({aLine, fLine}), (c <= 10) ? 32'({ai, fi}) : 32'd0);
            end
            if (c == 13) begin
                checkOutput({tag, "_rdata"}, 32'(rspRdata), 32'(expRdata));
                checkOutput({tag, "_qx"}, 32'({rspQ, rspX}), 32'({expQ, expX}));
            end
            if (c < 13) waitCycle();
        end
    endtask

`ifdef CAMAC_MASTER_QREP_EN
    // Q-repeat run: q becomes 1 from attempt qOneAt onward (0 = never).
    task automatic applyQrepStimulus(input string tag, input logic [4:0] n, input int qOneAt,
                                     input int expPulses, input logic expQ);
        int  pulses     = 0;
        int  validCount = 0;
        bit  prevS1     = 1'b0;
        bit  seen       = 1'b0;
        checkOutput({tag, "_ready"}, 32'(reqReady), 32'd1);
        reqN     = n;
        reqA     = 4'd1;
        reqF     = 5'd8;
        reqWdata = 24'h0;
        reqQrep  = 1'b1;
        qLine    = (qOneAt == 1);
        xLine    = 1'b1;
        reqValid = 1'b1;
        waitCycle();
        reqValid = 1'b0;
        reqQrep  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (prevS1 && !s1) qLine = (qOneAt != 0) && (pulses + 1 >= qOneAt);
            if (!prevS1 && s1) pulses++;
            prevS1 = s1;
            if (rspValid) begin
                seen = 1'b1;
                validCount++;
                checkOutput({tag, "_rspq"}, 32'(rspQ), 32'(expQ));
            end else begin
                waitCycle();
            end
        end
        checkOutput({tag, "_finished"}, 32'(seen), 32'd1);
        checkOutput({tag, "_pulses"}, 32'(pulses), 32'(expPulses));
        for (int i = 0; i < 15; i++) begin
            waitCycle();
            if (rspValid) validCount++;
        end
        checkOutput({tag, "_validcount"}, 32'(validCount), 32'd1);
    endtask
`endif

    // Main directed sequence
    initial begin
        int validSeen;
        rst      = 1'b0;
        reqValid = 1'b0;
        reqN     = '0;
        reqA     = '0;
        reqF     = '0;
        reqWdata = '0;
`ifdef CAMAC_MASTER_QREP_EN
        reqQrep  = 1'b0;
`endif
        readLine = '0;
        qLine    = 1'b0;
        xLine    = 1'b0;
        b2bN     = '0;
        b2bA     = '0;
        b2bF     = '0;
        b2bWdata = '0;

        repeat (3) waitCycle();
        checkOutput("reset_ctl", 32'(ctlVec()), 32'd0);
        checkOutput("reset_rsp", 32'({rspRdata, rspQ, rspX}), 32'd0);
        checkOutput("reset_lines", 32'(nSel | writeLine), 32'd0);
        checkOutput("reset_af", 32'({aLine, fLine}), 32'd0);

        rst = 1'b1;
        #1;
        checkOutput("release_ready_before_edge", 32'(reqReady), 32'd0);
        waitCycle();
        checkOutput("release_ready_after_edge", 32'({reqReady, bLine}), 32'b10);

        applyStimulus("write", 5'd5, 4'd2, 5'd16, 24'hABCDEF, 1'b1, 1'b1, 24'h555555,
                      24'h000010, 24'hABCDEF, 24'h0, 1'b1, 1'b1, 1'b0);
        waitCycle();
        applyStimulus("read24", 5'd24, 4'd0, 5'd0, 24'h111111, 1'b1, 1'b1, 24'h123456,
                      24'h800000, 24'h0, 24'h123456, 1'b1, 1'b1, 1'b0);
        waitCycle();
        applyStimulus("f27", 5'd3, 4'd7, 5'd27, 24'h222222, 1'b0, 1'b1, 24'h123456,
                      24'h000004, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0);
        waitCycle();
        applyStimulus("badn0", 5'd0, 4'd0, 5'd0, 24'h0, 1'b1, 1'b1, 24'hFFFFFF,
                      24'h0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        waitCycle();
        applyStimulus("badn25", 5'd25, 4'd1, 5'd1, 24'h0, 1'b1, 1'b1, 24'hFFFFFF,
                      24'h0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        waitCycle();

        b2bN     = 5'd9;
        b2bA     = 4'd3;
        b2bF     = 5'd17;
        b2bWdata = 24'h00C0DE;
        applyStimulus("b2b1", 5'd2, 4'd1, 5'd1, 24'h0, 1'b1, 1'b0, 24'h0000AA,
                      24'h000002, 24'h0, 24'h0000AA, 1'b1, 1'b0, 1'b1);
        waitCycle();
        reqValid = 1'b0;
        checkOutput("b2b2_setup_ctl", 32'(ctlVec()), 32'b01000);
        checkOutput("b2b2_setup_nsel", 32'(nSel), 32'h000100);
        checkOutput("b2b2_setup_write", 32'(writeLine), 32'h00C0DE);
        repeat (4) waitCycle();
        checkOutput("b2b2_s1", 32'(ctlVec()), 32'b01100);

        rst = 1'b0;
        #1;
        checkOutput("midreset_ctl", 32'(ctlVec()), 32'd0);
        checkOutput("midreset_lines", 32'(nSel | writeLine), 32'd0);
        validSeen = 0;
        repeat (3) begin
            waitCycle();
            if (rspValid) validSeen++;
        end
        rst = 1'b1;
        waitCycle();
        checkOutput("postreset_ready", 32'({reqReady, bLine}), 32'b10);
        repeat (14) begin
            waitCycle();
            if (rspValid || bLine) validSeen++;
        end
        checkOutput("postreset_no_rsp", 32'(validSeen), 32'd0);

`ifdef CAMAC_MASTER_QREP_EN
        applyQrepStimulus("qrep_001", 5'd4, 3, 3, 1'b1);
        waitCycle();
        applyQrepStimulus("qrep_never", 5'd4, 0, 16, 1'b0);
        waitCycle();
        applyQrepStimulus("qrep_badn", 5'd0, 0, 1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no completion, expected completion");
        mismatchCount++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
